// File: rtl/commit_queue_pkg.sv
// Shared core types for the rename/commit path: physical register tags and
// renamed instructions, plus the default commit queue depth.
package commit_queue_pkg;

    localparam int CQ_DEPTH = 16;
    localparam int PREG_W   = 6;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [PREG_W-1:0] idx;
    } p_reg_t;

    typedef struct packed {
        logic   valid;
        logic   is_branch;
        p_reg_t rd;
    } rinstr_t;

endpackage

// File: rtl/commit_queue.sv
// In-order commit queue: tracks renamed instructions until their destination
// is written back, then retires them from the head one per cycle.
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int DEPTH = CQ_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  rinstr_t                  rinstr_i,
    output logic                     cq_full_o,
    input  p_reg_t                   wb_i,
    output p_reg_t                   p_commit_o,
    output logic                     cq_empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic              r_busy     [DEPTH];
    logic              r_done     [DEPTH];
    logic              r_rd_valid [DEPTH];
    logic [PREG_W-1:0] r_rd_idx   [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;
    p_reg_t            r_commit;

    logic w_enq;
    logic w_retire;
    logic w_enq_done;
    logic w_unused;

    assign cq_full_o  = (r_count == FULL_CNT);
    assign cq_empty_o = (r_count == '0);
    assign count_o    = r_count;
    assign p_commit_o = r_commit;

    assign w_enq    = rinstr_i.valid && !cq_full_o;
    // done is a register, so the head retires only on the edge after it was set
    assign w_retire = r_busy[r_head] && r_done[r_head];
    // An entry with no destination, or whose destination is written back in
    // the enqueue cycle itself, starts out done.
    assign w_enq_done = !rinstr_i.rd.valid ||
                        (wb_i.valid && (wb_i.idx == rinstr_i.rd.idx));

    assign w_unused = ^{rinstr_i.is_branch, wb_i.ready};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]     <= 1'b0;
                r_done[i]     <= 1'b0;
                r_rd_valid[i] <= 1'b0;
                r_rd_idx[i]   <= '0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_commit <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_i.valid && r_busy[i] && r_rd_valid[i] && !r_done[i] &&
                    (r_rd_idx[i] == wb_i.idx))
                    r_done[i] <= 1'b1;
            end

            if (w_retire) begin
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + PW'(1);
            end

            // tail slot is never busy here, so it cannot collide with the retire
            if (w_enq) begin
                r_busy[r_tail]     <= 1'b1;
                r_done[r_tail]     <= w_enq_done;
                r_rd_valid[r_tail] <= rinstr_i.rd.valid;
                r_rd_idx[r_tail]   <= rinstr_i.rd.idx;
                r_tail             <= r_tail + PW'(1);
            end

            case ({w_enq, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_retire && r_rd_valid[r_head]) begin
                r_commit.valid <= 1'b1;
                r_commit.ready <= 1'b1;
                r_commit.idx   <= r_rd_idx[r_head];
            end else begin
                r_commit <= '0;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni)
            assert (!(rinstr_i.valid && cq_full_o))
                else $warning("commit_queue: protocol error, instruction presented while full was dropped");
    end
`endif

endmodule

// File: doc/commit_queue.md
COMMIT_QUEUE -- requirements
Module: commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of in-flight renamed instructions; power of two, at least 2.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rinstr_i  input  rinstr_t  renamed instruction from rename; enqueued when valid is set.
REQ-005 SHALL have port cq_full_o  input-side flow control, output  1  high when occupancy equals DEPTH; rename holds rinstr_i.valid low while it is high.
REQ-006 SHALL have port wb_i  input  p_reg_t  execution writeback; valid and idx name the physical destination just produced; ready is ignored.
REQ-007 SHALL have port p_commit_o  output  p_reg_t  in-order commit notification to rename; ready equals valid.
REQ-008 SHALL have port cq_empty_o  output  1  high when occupancy is 0.
REQ-009 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-010 SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0. Occupancy is held in a separate counter.
REQ-011 SHALL store the following per entry:
- busy
- done
- rd.valid
- rd.idx (6 bits)
REQ-012 SHALL enqueue at the tail on a rising edge when rinstr_i.valid=1 and cq_full_o=0.
REQ-013 SHALL set done at enqueue when rinstr_i.rd.valid=0, because the entry has no destination to wait for.
REQ-014 SHALL, on wb_i.valid=1, set done on the single busy entry with rd.valid=1, rd.idx==wb_i.idx and done=0.
REQ-015 SHALL ignore a writeback that matches no entry; no state changes.
REQ-016 SHALL also set done on an entry enqueued in the same cycle when wb_i targets that entry's rd.idx (same-cycle bypass).
REQ-017 SHALL retire the head entry on a rising edge when it is busy and its done bit was already set before that edge.
- Earliest commit is the edge after the one that set done.
- At most one retire per cycle.
REQ-018 SHALL drive p_commit_o registered on retire:
- retiring entry has rd.valid=1: valid=1, idx=rd.idx, ready=1 for exactly one cycle.
- otherwise: p_commit_o.valid=0 (silent retire).
REQ-019 SHALL hold p_commit_o at all-zero in every cycle without a committing retire.
REQ-020 SHALL handle simultaneous enqueue and retire as follows: occupancy unchanged, both pointers advance.
REQ-021 SHALL compute cq_full_o from registered occupancy only, so a same-cycle retire does not allow an enqueue while full.
REQ-022 SHALL drop rinstr_i with valid=1 while cq_full_o=1. A simulation assertion SHALL flag it as a protocol error.
REQ-023 SHALL hold the head when the head is not done; younger done entries wait (strict program order).
REQ-024 SHALL treat br_result_t and branch recovery as out of scope; is_branch entries behave per REQ-013.

Reset
REQ-025 SHALL, while rst_ni=0, clear the following regardless of the clock:
- pointers, occupancy, all busy and done bits;
- p_commit_o all-zero;
- cq_full_o=0, cq_empty_o=1, count_o=0.
REQ-026 SHALL discard all in-flight entries on reset mid-operation, with no commit emitted during or after reset.
REQ-027 SHALL accept an enqueue on the first rising edge after rst_ni deasserts.

Structure
REQ-028 SHALL take rinstr_t and p_reg_t from the shared core package, and SHALL add CQ_DEPTH (16) to that package as the default for DEPTH.
REQ-029 SHALL be a single module with no sub-modules; the entry array is flops, not a memory macro.

Verification
REQ-030 SHALL be covered by these directed scenarios:
- Enqueue rd=40, then rd=41; writeback 41 then 40 -> commit 40 then 41, each valid one cycle, 41 never before 40.
- Enqueue an entry with rd.valid=0 at edge k, none before it -> silent retire at edge k+1, p_commit_o.valid=0, count_o back to 0.
- Fill 16 entries with no writebacks -> cq_full_o=1, count_o=16; a 17th rinstr_i is dropped and flagged; writeback the head -> full drops two edges later.
- Same-cycle enqueue of rd=33 and wb_i.idx=33 with queue empty -> commit 33 visible after the second edge.
- Wrap: 40 enqueue/commit pairs at DEPTH=16 -> in-order commits, pointers wrap, no lost or duplicate idx.
- 5 busy entries, rst_ni low asynchronously between edges -> outputs clear immediately, and a following writeback of an old idx commits nothing.
